// File: rtl/adder_share_ctrl_pkg.sv
// adder_share_ctrl_pkg: shared datapath width, result record and overflow helper
package adder_share_ctrl_pkg;
    localparam int DATA_W = 33;
    typedef struct packed {
        logic              ovf;
        logic              cout;
        logic [DATA_W-1:0] sum;
    } add_res_t;
    // the carry into the MSB is recovered from the MSB sum bit
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb, input logic cout);
        return cout ^ (a_msb ^ b_msb ^ s_msb);
    endfunction
endpackage

// File: rtl/adder_33.sv
// adder_33: plain 33-bit adder with carry-in and carry-out
module adder_33 (
    input  logic [32:0] a,
    input  logic [32:0] b,
    input  logic        cin,
    output logic [32:0] sum,
    output logic        cout
);
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {33'd0, cin};
endmodule

// File: rtl/adder_share_ctrl_arb.sv
// adder_rr_arb: round-robin one-hot arbiter with pointer advanced past each winner
module adder_rr_arb #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    input  logic            upd,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] id
);
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic            found;
    // first pass covers ptr..NREQ-1, second pass wraps to 0..ptr-1
    always_comb begin
        grant = '0;
        id    = '0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++)
            if (en && !found && req[i] && i >= int'(ptr_q)) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                id       = ID_W'(i);
            end
        for (int i = 0; i < NREQ; i++)
            if (en && !found && req[i] && i < int'(ptr_q)) begin
                found    = 1'b1;
                grant[i] = 1'b1;
                id       = ID_W'(i);
            end
    end
    always_comb ptr_d = upd ? ((id == ID_W'(NREQ-1)) ? '0 : id + 1'b1) : ptr_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
endmodule

// File: rtl/adder_share_ctrl.sv
// adder_share_ctrl: round-robin sharing of one 33-bit adder with a single result slot
module adder_share_ctrl
    import adder_share_ctrl_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_a,
    input  logic [NREQ*DATA_W-1:0] req_b,
    input  logic [NREQ-1:0]        req_cin,
    input  logic [NREQ-1:0]        req_sub,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [DATA_W-1:0]      rsp_sum,
    output logic                   rsp_cout,
    output logic                   rsp_overflow
);
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    add_res_t          res_q, res_d, res_new;
    logic              free, xfer;
    logic [NREQ-1:0]   grant;
    logic [ID_W-1:0]   gid;
    logic [DATA_W-1:0] op_a, op_b, sum;
    logic              op_sub, op_cin, cout;
    assign free = !rsp_valid_q || rsp_ready;
    adder_rr_arb #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_valid),
        .en    (free && rst_n),
        .upd   (xfer),
        .grant (grant),
        .id    (gid)
    );
    assign req_ready = grant;
    assign xfer      = |grant;
    // subtract is A + ~B + 1 through the same adder
    always_comb begin
        op_a    = req_a[DATA_W*int'(gid) +: DATA_W];
        op_sub  = req_sub[gid];
        op_b    = op_sub ? ~req_b[DATA_W*int'(gid) +: DATA_W] : req_b[DATA_W*int'(gid) +: DATA_W];
        op_cin  = op_sub | req_cin[gid];
        res_new = '{ovf: signed_ovf(op_a[DATA_W-1], op_b[DATA_W-1], sum[DATA_W-1], cout), cout: cout, sum: sum};
    end
    adder_33 u_add (
        .a    (op_a),
        .b    (op_b),
        .cin  (op_cin),
        .sum  (sum),
        .cout (cout)
    );
    always_comb begin
        rsp_valid_d = xfer ? 1'b1 : (rsp_ready ? 1'b0 : rsp_valid_q);
        rsp_id_d    = xfer ? gid : rsp_id_q;
        res_d       = xfer ? res_new : res_q;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            res_q       <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            res_q       <= res_d;
        end
    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_sum      = res_q.sum;
    assign rsp_cout     = res_q.cout;
    assign rsp_overflow = res_q.ovf;
endmodule

// File: tb/tb_adder_share_ctrl.sv
// tb_adder_share_ctrl: scenario tasks plus randomized traffic against an arithmetic reference model
module tb_adder_share_ctrl;
    localparam int NREQ = 4;
    localparam int ID_W = 2;
    localparam int W    = 33;
    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req_valid = '0, req_ready, req_cin = '0, req_sub = '0;
    logic [NREQ*W-1:0]   req_a, req_b;
    logic                rsp_valid, rsp_ready = 1'b0;
    logic [ID_W-1:0]     rsp_id;
    logic [W-1:0]        rsp_sum;
    logic                rsp_cout, rsp_overflow;
    logic [W-1:0]        op_a [NREQ];
    logic [W-1:0]        op_b [NREQ];
    logic [37:0]         obs;
    int                  checks = 0, passes = 0;
    logic                m_valid;
    logic [ID_W-1:0]     m_id;
    logic [34:0]         m_res;
    int                  m_ptr;
    logic [NREQ-1:0]     m_last_g;

    adder_share_ctrl #(.NREQ(NREQ), .ID_W(ID_W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_sub(req_sub),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_overflow(rsp_overflow)
    );

    always #5 clk = ~clk;
    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[W*i +: W] = op_a[i];
            req_b[W*i +: W] = op_b[i];
        end
    end
    assign obs = {rsp_valid, rsp_id, rsp_overflow, rsp_cout, rsp_sum};

    function automatic logic [34:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
        logic [33:0]  full;
        logic [W-1:0] s;
        logic         c, v;
        if (sub) begin
            s = a - b;
            c = (a >= b);
            v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
        end else begin
            full = {1'b0, a} + {1'b0, b} + 34'(cin);
            s = full[W-1:0];
            c = full[33];
            v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        end
        return {v, c, s};
    endfunction

    function automatic logic [NREQ-1:0] m_grant();
        logic [NREQ-1:0] g;
        int j;
        g = '0;
        if (!rst_n || (m_valid && !rsp_ready)) return g;
        for (int k = 0; k < NREQ; k++) begin
            j = (m_ptr + k) % NREQ;
            if (req_valid[j]) begin
                g[j] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    function automatic logic [W-1:0] rnd33();
        logic [31:0] h;
        h = $urandom;
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return 33'h0_FFFF_FFFF;
            3:       return 33'h1_0000_0000;
            default: return {h[0], 32'($urandom)};
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_id = '0; m_res = '0; m_ptr = 0; m_last_g = '0;
    endtask

    task automatic advance();
        logic [NREQ-1:0] g;
        g = m_grant();
        @(posedge clk);
        m_last_g = g;
        if (g != '0) begin
            for (int i = 0; i < NREQ; i++)
                if (g[i]) begin
                    m_valid = 1'b1;
                    m_id    = ID_W'(i);
                    m_res   = ref_op(op_a[i], op_b[i], req_cin[i], req_sub[i]);
                    m_ptr   = (i + 1) % NREQ;
                end
        end else if (rsp_ready) m_valid = 1'b0;
        #1;
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
        op_a[i] = a; op_b[i] = b; req_cin[i] = cin; req_sub[i] = sub;
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst_n = 1'b0;
        #2;
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, '0, '0, 1'b0, 1'b0);
        model_reset();
        #1;
        checks++; if (req_ready !== '0) $display("FAIL reset_ready got %b want 0", req_ready); else passes++;
        checks++; if (obs !== '0) $display("FAIL reset_out got %h want 0", obs); else passes++;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        set_op(2, 33'd1, 33'd2, 1'b0, 1'b0);
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        #1;
        checks++; if (req_ready !== m_grant()) $display("FAIL pre_ready got %b want %b", req_ready, m_grant()); else passes++;
        advance();
        req_valid = '0;
        checks++; if (obs !== {m_valid, m_id, m_res} || !rsp_valid) $display("FAIL pre_slot got %h want %h", obs, {m_valid, m_id, m_res}); else passes++;
        req_valid = '1;
        #1 rst_n = 1'b0;
        #1;
        checks++; if (obs !== '0) $display("FAIL midreset_out got %h want 0", obs); else passes++;
        checks++; if (req_ready !== '0) $display("FAIL midreset_ready got %b want 0", req_ready); else passes++;
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) $display("FAIL postreset_ptr got %b want 0001", req_ready); else passes++;
        advance();
        req_valid = '0;
        checks++; if (obs !== {m_valid, m_id, m_res} || rsp_id !== 2'd0) $display("FAIL postreset_rsp got %h want %h", obs, {m_valid, m_id, m_res}); else passes++;
    endtask

    task automatic test_single();
        rsp_ready = 1'b1;
        set_op(0, 33'd5, 33'd7, 1'b1, 1'b0);
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) $display("FAIL add_ready got %b want 0001", req_ready); else passes++;
        advance();
        req_valid = '0;
        checks++; if ({rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_overflow} !== {1'b1, 2'd0, 33'd13, 1'b0, 1'b0})
            $display("FAIL add_5_7 got sum=%h id=%0d cout=%b ovf=%b want sum=d id=0 cout=0 ovf=0", rsp_sum, rsp_id, rsp_cout, rsp_overflow); else passes++;
        set_op(0, 33'd5, 33'd7, 1'b0, 1'b1);
        req_valid = 4'b0001;
        advance();
        req_valid = '0;
        checks++; if ({rsp_sum, rsp_cout} !== {33'h1_FFFF_FFFE, 1'b0})
            $display("FAIL sub_5_7 got sum=%h cout=%b want sum=1fffffffe cout=0", rsp_sum, rsp_cout); else passes++;
        checks++; if (obs !== {m_valid, m_id, m_res}) $display("FAIL sub_model got %h want %h", obs, {m_valid, m_id, m_res}); else passes++;
    endtask

    task automatic test_overflow();
        set_op(0, 33'h0_FFFF_FFFF, 33'd1, 1'b0, 1'b0);
        req_valid = 4'b0001;
        advance();
        req_valid = '0;
        checks++; if ({rsp_sum, rsp_cout, rsp_overflow} !== {33'h1_0000_0000, 1'b0, 1'b1})
            $display("FAIL ovf_pos got sum=%h cout=%b ovf=%b want sum=100000000 cout=0 ovf=1", rsp_sum, rsp_cout, rsp_overflow); else passes++;
        set_op(0, 33'h1_FFFF_FFFF, 33'd1, 1'b0, 1'b0);
        req_valid = 4'b0001;
        advance();
        req_valid = '0;
        checks++; if ({rsp_sum, rsp_cout, rsp_overflow} !== {33'd0, 1'b1, 1'b0})
            $display("FAIL ovf_wrap got sum=%h cout=%b ovf=%b want sum=0 cout=1 ovf=0", rsp_sum, rsp_cout, rsp_overflow); else passes++;
    endtask

    task automatic test_round_robin();
        do_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_op(i, rnd33(), rnd33(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        req_valid = '1;
        for (int k = 0; k < 12; k++) begin
            #1;
            checks++; if (req_ready !== (NREQ'(1) << (k % NREQ))) $display("FAIL rr_grant k=%0d got %b want %b", k, req_ready, NREQ'(1) << (k % NREQ)); else passes++;
            advance();
            checks++; if (!rsp_valid || rsp_id !== ID_W'(k % NREQ) || obs !== {m_valid, m_id, m_res})
                $display("FAIL rr_rsp k=%0d got %h want %h", k, obs, {m_valid, m_id, m_res}); else passes++;
            set_op(k % NREQ, rnd33(), rnd33(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        logic [37:0] held;
        do_reset();
        rsp_ready = 1'b0;
        set_op(0, rnd33(), rnd33(), 1'b0, 1'b0);
        req_valid = 4'b0001;
        advance();
        held = obs;
        set_op(1, rnd33(), rnd33(), 1'b1, 1'b0);
        set_op(2, rnd33(), rnd33(), 1'b0, 1'b1);
        req_valid = 4'b0110;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (req_ready !== '0) $display("FAIL bp_ready k=%0d got %b want 0", k, req_ready); else passes++;
            advance();
            checks++; if (obs !== held || obs !== {m_valid, m_id, m_res}) $display("FAIL bp_hold k=%0d got %h want %h", k, obs, held); else passes++;
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010) $display("FAIL bp_drain_grant got %b want 0010", req_ready); else passes++;
        advance();
        req_valid = 4'b0100;
        checks++; if (rsp_id !== 2'd1 || obs !== {m_valid, m_id, m_res}) $display("FAIL bp_req1 got %h want %h", obs, {m_valid, m_id, m_res}); else passes++;
        #1;
        checks++; if (req_ready !== 4'b0100) $display("FAIL bp_next_grant got %b want 0100", req_ready); else passes++;
        advance();
        req_valid = '0;
        checks++; if (rsp_id !== 2'd2 || obs !== {m_valid, m_id, m_res}) $display("FAIL bp_req2 got %h want %h", obs, {m_valid, m_id, m_res}); else passes++;
        advance();
    endtask

    task automatic test_withdraw();
        do_reset();
        rsp_ready = 1'b0;
        set_op(0, rnd33(), rnd33(), 1'b0, 1'b0);
        req_valid = 4'b0001;
        advance();
        set_op(3, rnd33(), rnd33(), 1'b0, 1'b0);
        req_valid = 4'b1000;
        #1;
        checks++; if (req_ready !== '0) $display("FAIL wd_ready got %b want 0", req_ready); else passes++;
        advance();
        req_valid = '0;
        rsp_ready = 1'b1;
        advance();
        checks++; if (rsp_valid !== 1'b0) $display("FAIL wd_drain got %b want 0", rsp_valid); else passes++;
        set_op(0, rnd33(), rnd33(), 1'b0, 1'b0);
        set_op(2, rnd33(), rnd33(), 1'b0, 1'b0);
        req_valid = 4'b0101;
        #1;
        checks++; if (req_ready !== 4'b0100) $display("FAIL wd_ptr got %b want 0100", req_ready); else passes++;
        for (int k = 0; k < 4; k++) begin
            advance();
            checks++; if (rsp_valid && rsp_id === 2'd3) $display("FAIL wd_id k=%0d got 3 want not 3", k); else passes++;
        end
        req_valid = '0;
        advance();
    endtask

    task automatic test_random();
        logic [NREQ-1:0] v;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            v = req_valid;
            for (int i = 0; i < NREQ; i++) begin
                if (v[i] && !m_last_g[i]) begin
                    if ($urandom_range(0, 9) == 0) v[i] = 1'b0;
                end else begin
                    v[i] = 1'($urandom_range(0, 1));
                    set_op(i, rnd33(), rnd33(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
            end
            req_valid = v;
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks++; if (req_ready !== m_grant()) $display("FAIL rnd_ready c=%0d got %b want %b", c, req_ready, m_grant()); else passes++;
            checks++; if (obs !== {m_valid, m_id, m_res}) $display("FAIL rnd_rsp c=%0d got %h want %h", c, obs, {m_valid, m_id, m_res}); else passes++;
            advance();
        end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_round_robin();
        test_backpressure();
        test_withdraw();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
